squeeze_conv1x1_engine: RTL and testbench

Parametrised 1x1 convolution (squeeze) engine that generalises the per-layer fire squeeze blocks into one reusable core. Streams CHIN input channels per output pixel and buffers them locally. Computes CHOUT output channels in CHOUT/DSP_NO passes of DSP_NO parallel MAC lanes. Emits rounded, saturated fixed-point results through a valid/ready handshake. Sits between the feature-map RAM reader and the fire expand stage.

---
 rtl/squeeze_conv1x1_engine_if.sv | 38 +++
 rtl/squeeze_conv1x1_engine.sv | 173 +++++++++++++++++
 tb/tb_squeeze_conv1x1_engine.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/squeeze_conv1x1_engine_if.sv
// Handshake/bus bundle for squeeze_conv1x1_engine.
//   master: the upstream/downstream side (feature-map reader, weight ROM, expand stage)
//   slave : the engine itself
// Signals: squeeze_en start request; ifm/ifm_valid/ifm_ready activation stream;
// wt_addr/w_bus weight row lookup (same-cycle); ofm/ofm_group/ofm_valid/ofm_ready
// result stream; busy and squeeze_finish status.
interface squeeze_conv1x1_engine_if #(
  parameter int WIDTH  = 16,
  parameter int CHIN   = 64,
  parameter int CHOUT  = 16,
  parameter int DSP_NO = 16
);
  localparam int NG = CHOUT / DSP_NO;
  localparam int WA = $clog2(CHIN * NG);
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  logic                           squeeze_en;
  logic [WIDTH-1:0]               ifm;
  logic                           ifm_valid;
  logic                           ifm_ready;
  logic [WA-1:0]                  wt_addr;
  logic [DSP_NO-1:0][WIDTH-1:0]   w_bus;
  logic [DSP_NO-1:0][WIDTH-1:0]   ofm;
  logic [GW-1:0]                  ofm_group;
  logic                           ofm_valid;
  logic                           ofm_ready;
  logic                           busy;
  logic                           squeeze_finish;

  modport master (
    output squeeze_en, ifm, ifm_valid, w_bus, ofm_ready,
    input  ifm_ready, wt_addr, ofm, ofm_group, ofm_valid, busy, squeeze_finish
  );
  modport slave (
    input  squeeze_en, ifm, ifm_valid, w_bus, ofm_ready,
    output ifm_ready, wt_addr, ofm, ofm_group, ofm_valid, busy, squeeze_finish
  );
endinterface

// File: rtl/squeeze_conv1x1_engine.sv
// 1x1 convolution (squeeze) engine. Each pixel's CHIN channels are streamed in once,
// buffered, and replayed for every further group of DSP_NO output channels. Each lane
// accumulates full-precision products, then rounds, shifts by FRAC and saturates.
// Ports: clk, rst (async, active high), sif (squeeze_conv1x1_engine_if.slave).
// Optional build macro: SQUEEZE_RELU_EN -- fuses a ReLU after saturation.

// One MAC lane: accumulator plus round/shift/saturate into a registered result.
module squeeze_conv1x1_lane #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int AW    = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] w,
  input  logic                    mac_en,
  input  logic                    acc_clr,
  input  logic                    sat_en,
  output logic [WIDTH-1:0]        res
);
  // (1<<FRAC)>>1 is half an LSB of the output, and 0 when FRAC=0
  localparam logic signed [AW-1:0] RND  = AW'((1 << FRAC) >> 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      acc;
  logic signed [AW-1:0]      rounded;
  logic [WIDTH-1:0]          sat;

  assign prod    = x * w;
  assign rounded = (acc + RND) >>> FRAC;

  always_comb begin
    if (rounded > MAXV)      sat = MAXV[WIDTH-1:0];
    else if (rounded < MINV) sat = MINV[WIDTH-1:0];
    else                     sat = rounded[WIDTH-1:0];
`ifdef SQUEEZE_RELU_EN
    if (sat[WIDTH-1]) sat = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (sat_en) res <= sat;
      if (acc_clr)     acc <= '0;
      else if (mac_en) acc <= acc + AW'(prod);
    end
  end
endmodule

module squeeze_conv1x1_engine #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 8,
  parameter int CHIN   = 64,
  parameter int CHOUT  = 16,
  parameter int DSP_NO = 16,
  parameter int WOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  squeeze_conv1x1_engine_if.slave  sif
);
  localparam int NG  = CHOUT / DSP_NO;
  localparam int PIX = WOUT * WOUT;
  localparam int WA  = $clog2(CHIN * NG);
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int CW  = $clog2(CHIN);
  localparam int PW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int AW  = 2 * WIDTH + $clog2(CHIN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_REPLAY = 3'd2;
  localparam logic [2:0] S_SAT    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                   state;
  logic [CW-1:0]                ch;
  logic [GW-1:0]                group;
  logic [PW-1:0]                pixel;
  logic [GW-1:0]                ofm_group_q;
  logic [WIDTH-1:0]             ifm_buf [CHIN];
  logic [WIDTH-1:0]             x_sel;
  logic [DSP_NO-1:0][WIDTH-1:0] ofm_q;
  logic                         start, load_fire, mac_en, sat_en, acc_clr, last_ch;

  assign start     = (state == S_IDLE) && sif.squeeze_en;
  assign load_fire = (state == S_LOAD) && sif.ifm_valid;
  assign mac_en    = load_fire || (state == S_REPLAY);
  assign sat_en    = (state == S_SAT);
  assign acc_clr   = start || sat_en;
  assign last_ch   = (ch == CW'(CHIN - 1));
  // group 0 MACs the live stream; later groups replay the stored pixel
  assign x_sel     = (state == S_LOAD) ? sif.ifm : ifm_buf[ch];

  assign sif.wt_addr        = WA'(group) * WA'(CHIN) + WA'(ch);
  assign sif.ifm_ready      = (state == S_LOAD);
  assign sif.ofm_valid      = (state == S_DRAIN);
  assign sif.busy           = (state != S_IDLE);
  assign sif.squeeze_finish = (state == S_DONE);
  assign sif.ofm_group      = ofm_group_q;
  assign sif.ofm            = ofm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ch          <= '0;
      group       <= '0;
      pixel       <= '0;
      ofm_group_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (sif.squeeze_en) begin
          state <= S_LOAD;
          ch    <= '0;
          group <= '0;
          pixel <= '0;
        end
        S_LOAD: if (sif.ifm_valid) begin
          if (last_ch) state <= S_SAT;
          else         ch    <= ch + CW'(1);
        end
        S_REPLAY: begin
          if (last_ch) state <= S_SAT;
          else         ch    <= ch + CW'(1);
        end
        S_SAT: begin
          ofm_group_q <= group;
          ch          <= '0;
          state       <= S_DRAIN;
        end
        S_DRAIN: if (sif.ofm_ready) begin
          if (group != GW'(NG - 1)) begin
            group <= group + GW'(1);
            state <= S_REPLAY;
          end else if (pixel != PW'(PIX - 1)) begin
            pixel <= pixel + PW'(1);
            group <= '0;
            state <= S_LOAD;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // pixel buffer needs no reset: LOAD rewrites every entry before REPLAY reads it
  always_ff @(posedge clk) begin
    if (load_fire) ifm_buf[ch] <= sif.ifm;
  end

  for (genvar k = 0; k < DSP_NO; k++) begin : g_lane
    squeeze_conv1x1_lane #(.WIDTH(WIDTH), .FRAC(FRAC), .AW(AW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .x       (x_sel),
      .w       (sif.w_bus[k]),
      .mac_en  (mac_en),
      .acc_clr (acc_clr),
      .sat_en  (sat_en),
      .res     (ofm_q[k])
    );
  end
endmodule

// File: tb/tb_squeeze_conv1x1_engine.sv
// Bench for squeeze_conv1x1_engine: two instances (FRAC=0 and FRAC=8) run in lockstep
// on shared stimulus; each beat is compared against an arithmetic reference model.
module tb_squeeze_conv1x1_engine;
  localparam int W = 16, CHIN = 4, CHOUT = 4, NL = 2, WOUT = 2;
  localparam int NG = CHOUT / NL, PIX = WOUT * WOUT, NB = PIX * NG, ROWS = CHIN * NG;

  logic clk = 0, rst = 0, en = 0, ifm_valid = 0, ofm_ready = 0;
  logic [W-1:0] ifm = '0;
  logic [NL-1:0][W-1:0] wmem [ROWS];
  logic [W-1:0] xin [PIX*CHIN];
  logic [NL-1:0][W-1:0] obs0[$], obs1[$];
  logic [0:0] obsg[$];
  int checks = 0, errors = 0;
  int n_hs, fin_cnt, fin_gap, lat_bad, bp_bad, tmo;

  always #5 clk = ~clk;

  squeeze_conv1x1_engine_if #(.WIDTH(W), .CHIN(CHIN), .CHOUT(CHOUT), .DSP_NO(NL)) bus0 ();
  squeeze_conv1x1_engine_if #(.WIDTH(W), .CHIN(CHIN), .CHOUT(CHOUT), .DSP_NO(NL)) bus1 ();

  assign bus0.squeeze_en = en;        assign bus1.squeeze_en = en;
  assign bus0.ifm        = ifm;       assign bus1.ifm        = ifm;
  assign bus0.ifm_valid  = ifm_valid; assign bus1.ifm_valid  = ifm_valid;
  assign bus0.ofm_ready  = ofm_ready; assign bus1.ofm_ready  = ofm_ready;
  assign bus0.w_bus      = wmem[bus0.wt_addr];
  assign bus1.w_bus      = wmem[bus1.wt_addr];

  squeeze_conv1x1_engine #(.WIDTH(W), .FRAC(0), .CHIN(CHIN), .CHOUT(CHOUT), .DSP_NO(NL), .WOUT(WOUT))
    u_dut0 (.clk(clk), .rst(rst), .sif(bus0));
  squeeze_conv1x1_engine #(.WIDTH(W), .FRAC(8), .CHIN(CHIN), .CHOUT(CHOUT), .DSP_NO(NL), .WOUT(WOUT))
    u_dut1 (.clk(clk), .rst(rst), .sif(bus1));

  // Reference: beat i is pixel i/NG, group i%NG; lane k = output channel g*NL+k.
  function automatic logic [NL-1:0][W-1:0] exp_beat(input int i, input int frac);
    logic [NL-1:0][W-1:0] r;
    longint acc;
    int p, g;
    p = i / NG;
    g = i % NG;
    for (int k = 0; k < NL; k++) begin
      acc = 0;
      for (int c = 0; c < CHIN; c++)
        acc += longint'($signed(xin[p*CHIN+c])) * longint'($signed(wmem[g*CHIN+c][k]));
      if (frac > 0) acc = (acc + (longint'(1) << (frac - 1))) >>> frac;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`ifdef SQUEEZE_RELU_EN
      if (acc < 0) acc = 0;
`endif
      r[k] = W'(acc);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rval();
    if ($urandom_range(0, 1) != 0) return W'($urandom);
    return W'(int'($urandom_range(0, 511)) - 256);
  endfunction

  task automatic fill_const(input logic [W-1:0] xv, input logic [W-1:0] wv);
    for (int i = 0; i < PIX*CHIN; i++) xin[i] = xv;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < NL; k++) wmem[r][k] = wv;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < PIX*CHIN; i++) xin[i] = rval();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < NL; k++) wmem[r][k] = rval();
  endtask

  // Drives one full run from IDLE and records beats/timing; ends on the cycle
  // squeeze_finish is seen (or after a cycle budget, flagged in tmo).
  task automatic run_engine(input bit stall, input bit bp, input bit hold);
    int cyc = 0, feed = 0, hold_cnt = 0, last_acc = -100, last_beat = -100, exp_cyc;
    bit in_drain = 0, done = 0;
    logic [NL-1:0][W-1:0] h0 = '0, h1 = '0;
    logic [0:0] hg = '0;
    logic [2:0] hwa = '0;
    obs0.delete(); obs1.delete(); obsg.delete();
    n_hs = 0; fin_cnt = 0; fin_gap = -1; lat_bad = 0; bp_bad = 0; tmo = 0;
    @(negedge clk);
    en = 1; ifm_valid = 0; ofm_ready = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold) en = 0;
      if (bus0.squeeze_finish === 1'b1) begin
        fin_cnt++; fin_gap = cyc - last_beat; done = 1;
      end
      if (bus0.ofm_valid === 1'b1 && !in_drain) begin
        in_drain = 1; hold_cnt = 0;
        h0 = bus0.ofm; h1 = bus1.ofm; hg = bus0.ofm_group; hwa = bus0.wt_addr;
        exp_cyc = (hg == 0) ? last_acc + 2 : last_beat + CHIN + 2;
        if (cyc != exp_cyc) lat_bad++;
      end else if (bp && in_drain) begin
        if (bus0.ofm_valid !== 1'b1 || bus0.ofm !== h0 || bus1.ofm !== h1 ||
            bus0.ofm_group !== hg || bus0.wt_addr !== hwa || bus0.ifm_ready !== 1'b0) bp_bad++;
      end
      ofm_ready = !bp || hold_cnt >= 5;
      if (in_drain) begin
        hold_cnt++;
        if (ofm_ready) begin
          obs0.push_back(bus0.ofm); obs1.push_back(bus1.ofm); obsg.push_back(bus0.ofm_group);
          last_beat = cyc; in_drain = 0;
        end
      end
      ifm_valid = (feed < PIX*CHIN) && (!stall || cyc[0]);
      ifm = ifm_valid ? xin[feed] : W'($urandom);
      if (ifm_valid && bus0.ifm_ready === 1'b1) begin
        n_hs++;
        if (feed % CHIN == CHIN - 1) last_acc = cyc;
        feed++;
      end
    end
    if (!done) tmo = 1;
    ifm_valid = 0; ofm_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.busy !== 0 || bus0.ofm_valid !== 0 || bus0.ifm_ready !== 0 || bus0.squeeze_finish !== 0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b ofm_valid=%b ifm_ready=%b fin=%b, want all 0",
               bus0.busy, bus0.ofm_valid, bus0.ifm_ready, bus0.squeeze_finish);
    end
    checks++;
    if (bus0.ofm !== '0 || bus1.ofm !== '0 || bus0.ofm_group !== '0 || bus0.wt_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: ofm=%h/%h grp=%b addr=%h, want 0", bus0.ofm, bus1.ofm, bus0.ofm_group, bus0.wt_addr);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_const(16'h0001, 16'h0002);
    run_engine(0, 0, 0);
    checks++;
    if (tmo != 0 || obs0.size() != NB) begin
      errors++; $display("FAIL basic_beats: got %0d (timeout %0d), want %0d", obs0.size(), tmo, NB);
    end
    for (int i = 0; i < obs0.size() && i < NB; i++) begin
      checks++;
      if (obs0[i] !== {16'd8, 16'd8} || obs1[i] !== exp_beat(i, 8) || obsg[i] !== 1'(i % NG)) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h/%h grp %b, want %h/%h grp %0d",
                 i, obs0[i], obs1[i], obsg[i], {16'd8, 16'd8}, exp_beat(i, 8), i % NG);
      end
    end
    checks++;
    if (n_hs != PIX*CHIN) begin errors++; $display("FAIL basic_handshakes: got %0d, want %0d", n_hs, PIX*CHIN); end
    checks++;
    if (fin_cnt != 1 || fin_gap != 1) begin errors++; $display("FAIL basic_finish: cnt %0d gap %0d, want 1 1", fin_cnt, fin_gap); end
    checks++;
    if (lat_bad != 0) begin errors++; $display("FAIL basic_latency: %0d late/early beats, want 0", lat_bad); end
    @(negedge clk);
    checks++;
    if (bus0.squeeze_finish !== 0 || bus0.busy !== 0) begin
      errors++; $display("FAIL basic_idle: fin=%b busy=%b, want 0 0", bus0.squeeze_finish, bus0.busy);
    end
  endtask

  task automatic test_random(input bit stall, input bit bp);
    for (int rep = 0; rep < 3; rep++) begin
      fill_rand();
      run_engine(stall, bp, 0);
      checks++;
      if (tmo != 0 || obs0.size() != NB || n_hs != PIX*CHIN) begin
        errors++; $display("FAIL rand_s%0d_b%0d_count: beats %0d hs %0d timeout %0d, want %0d %0d 0",
                           stall, bp, obs0.size(), n_hs, tmo, NB, PIX*CHIN);
      end
      for (int i = 0; i < obs0.size() && i < NB; i++) begin
        checks++;
        if (obs0[i] !== exp_beat(i, 0) || obs1[i] !== exp_beat(i, 8) || obsg[i] !== 1'(i % NG)) begin
          errors++;
          $display("FAIL rand_s%0d_b%0d_beat%0d: got %h/%h grp %b, want %h/%h grp %0d",
                   stall, bp, i, obs0[i], obs1[i], obsg[i], exp_beat(i, 0), exp_beat(i, 8), i % NG);
        end
      end
      checks++;
      if (lat_bad != 0 || bp_bad != 0 || fin_gap != 1) begin
        errors++; $display("FAIL rand_s%0d_b%0d_timing: lat %0d hold %0d fin_gap %0d, want 0 0 1",
                           stall, bp, lat_bad, bp_bad, fin_gap);
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] neg_exp;
`ifdef SQUEEZE_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    fill_const(16'h7FFF, 16'h7FFF);
    run_engine(0, 0, 0);
    for (int i = 0; i < obs0.size() && i < NB; i++) begin
      checks++;
      if (obs0[i] !== {16'h7FFF, 16'h7FFF} || obs1[i] !== exp_beat(i, 8)) begin
        errors++; $display("FAIL sat_pos_beat%0d: got %h/%h, want %h/%h", i, obs0[i], obs1[i], {16'h7FFF, 16'h7FFF}, exp_beat(i, 8));
      end
    end
    fill_const(16'h7FFF, 16'h8001);
    run_engine(0, 0, 0);
    checks++;
    if (obs0.size() != NB) begin errors++; $display("FAIL sat_neg_beats: got %0d, want %0d", obs0.size(), NB); end
    for (int i = 0; i < obs0.size() && i < NB; i++) begin
      checks++;
      if (obs0[i] !== {neg_exp, neg_exp} || obs1[i] !== exp_beat(i, 8)) begin
        errors++; $display("FAIL sat_neg_beat%0d: got %h/%h, want %h/%h", i, obs0[i], obs1[i], {neg_exp, neg_exp}, exp_beat(i, 8));
      end
    end
  endtask

  task automatic test_rounding();
    fill_const(16'h0000, 16'h0100);
    for (int p = 0; p < PIX; p++) xin[p*CHIN] = 16'h0180;
    run_engine(0, 0, 0);
    for (int i = 0; i < obs1.size() && i < NB; i++) begin
      checks++;
      if (obs1[i] !== {16'h0180, 16'h0180} || obs0[i] !== exp_beat(i, 0)) begin
        errors++; $display("FAIL round_a_beat%0d: got %h/%h, want %h/%h", i, obs1[i], obs0[i], {16'h0180, 16'h0180}, exp_beat(i, 0));
      end
    end
    fill_const(16'h0001, 16'h0080);
    run_engine(0, 0, 0);
    checks++;
    if (obs1.size() != NB) begin errors++; $display("FAIL round_b_beats: got %0d, want %0d", obs1.size(), NB); end
    for (int i = 0; i < obs1.size() && i < NB; i++) begin
      checks++;
      if (obs1[i] !== {16'h0002, 16'h0002} || obs0[i] !== {16'h0200, 16'h0200}) begin
        errors++; $display("FAIL round_b_beat%0d: got %h/%h, want 00020002/02000200", i, obs1[i], obs0[i]);
      end
    end
  endtask

  task automatic test_reset_midload();
    fill_const(16'h0001, 16'h0002);
    @(negedge clk); en = 1;
    @(negedge clk); en = 0; ifm_valid = 1; ifm = 16'h0005;
    @(negedge clk);
    @(negedge clk); ifm_valid = 0;
    checks++;
    if (bus0.ifm_ready !== 1 || bus0.wt_addr !== 3'd2) begin
      errors++; $display("FAIL midload_pre: ifm_ready=%b addr=%0d, want 1 2", bus0.ifm_ready, bus0.wt_addr);
    end
    rst = 1;
    #1;
    checks++;
    if (bus0.ofm_valid !== 0 || bus0.busy !== 0 || bus0.ifm_ready !== 0 || bus0.wt_addr !== 3'd0) begin
      errors++; $display("FAIL midload_rst: ofm_valid=%b busy=%b ifm_ready=%b addr=%0d, want 0 0 0 0",
                         bus0.ofm_valid, bus0.busy, bus0.ifm_ready, bus0.wt_addr);
    end
    @(negedge clk); rst = 0;
    run_engine(0, 0, 0);
    checks++;
    if (obs0.size() != NB || fin_cnt != 1) begin
      errors++; $display("FAIL midload_rerun: beats %0d fin %0d, want %0d 1", obs0.size(), fin_cnt, NB);
    end
    for (int i = 0; i < obs0.size() && i < NB; i++) begin
      checks++;
      if (obs0[i] !== {16'd8, 16'd8} || obsg[i] !== 1'(i % NG)) begin
        errors++; $display("FAIL midload_beat%0d: got %h grp %b, want 00080008 grp %0d", i, obs0[i], obsg[i], i % NG);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_rand();
    run_engine(0, 0, 1);
    for (int i = 0; i < obs0.size() && i < NB; i++) begin
      checks++;
      if (obs0[i] !== exp_beat(i, 0) || obs1[i] !== exp_beat(i, 8)) begin
        errors++; $display("FAIL b2b_beat%0d: got %h/%h, want %h/%h", i, obs0[i], obs1[i], exp_beat(i, 0), exp_beat(i, 8));
      end
    end
    @(negedge clk);
    checks++;
    if (bus0.busy !== 0) begin errors++; $display("FAIL b2b_idle: busy=%b, want 0", bus0.busy); end
    @(negedge clk);
    checks++;
    if (bus0.busy !== 1 || bus0.ifm_ready !== 1) begin
      errors++; $display("FAIL b2b_restart: busy=%b ifm_ready=%b, want 1 1", bus0.busy, bus0.ifm_ready);
    end
    en = 0;
    rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_random(0, 0);
    test_saturation();
    test_rounding();
    test_random(1, 0);
    test_random(0, 1);
    test_reset_midload();
    test_back_to_back();
    test_basic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
